md_issue_ctrl: RTL and testbench
================================

MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 40: divide-wait cycle limit before timeout.
REQ-002 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port rv32m, input, 1: M-extension instruction valid in EX.
REQ-005 SHALL have port func3, input, 3: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
REQ-006 SHALL have ports rs1 and rs2, input, 5 each: source register indices.
REQ-007 SHALL have ports a and b, input, 32 each: operands, stable while stall=1.
REQ-008 SHALL have port flush, input, 1: pipeline kill of the EX instruction.
REQ-009 SHALL have ports wb_we (1) and wb_rd (5), input: register-file write this cycle.
REQ-010 SHALL have ports c_mul, c_mulh, c_mulhsu, c_mulu, c_div, c_divu, c_rem, c_remu, input, 32 each: multiply/divide unit results.
REQ-011 SHALL have port div_ready, input, 1: divide unit done/idle.
REQ-012 SHALL have ports start_sdivide and start_udivide, output, 1 each: one-cycle divider start pulses.
REQ-013 SHALL have port stall, output, 1: freeze the pipeline upstream of EX.
REQ-014 SHALL have port md_result, output, 32: result for write-back.
REQ-015 SHALL have port md_valid, output, 1: md_result valid this cycle.
REQ-016 SHALL have port fuse, output, 1: result served from the fused quotient/remainder cache.
REQ-017 SHALL have port md_err, output, 1: divide timeout, result forced to 0.

Function
REQ-018 SHALL implement states IDLE, START, WAIT, DONE.
REQ-019 Multiply (func3[2]=0, rv32m=1) SHALL complete in IDLE with zero latency: md_valid=1, stall=0, md_result = c_mul/c_mulh/c_mulhsu/c_mulu per func3.
REQ-020 A divide with b==0 SHALL complete in zero latency without starting the divider: quotient 0xFFFFFFFF, remainder a.
REQ-021 Signed divide with a=0x80000000 and b=0xFFFFFFFF SHALL complete in zero latency: quotient 0x80000000, remainder 0.
REQ-022 Fuse hit SHALL require fuse_valid=1, rs1/rs2 equal to the stored indices, and func3[0] equal to the stored signedness; it SHALL complete in zero latency with fuse=1 and md_result = stored quotient (func3[1]=0) or stored remainder.
REQ-023 Any other divide in IDLE SHALL assert stall combinationally and go to START.
REQ-024 START SHALL last exactly one cycle, assert start_sdivide (func3[0]=0) or start_udivide (func3[0]=1), hold stall=1, and then go to WAIT.
REQ-025 WAIT SHALL hold stall=1, ignore div_ready in its first cycle, and go to DONE on the first later cycle with div_ready=1.
REQ-026 On the WAIT->DONE edge, the block SHALL latch c_div/c_divu into the quotient register and c_rem/c_remu into the remainder register, per signedness.
REQ-027 On the same edge, it SHALL set fuse_valid and store rs1, rs2 and signedness.
REQ-028 DONE SHALL last one cycle with stall=0 and md_valid=1, drive the latched quotient or remainder per func3[1], then return to IDLE.
REQ-029 A WAIT cycle counter SHALL time out: if div_ready has not been seen by wait cycle MAX_WAIT, go to DONE with md_err=1, md_result=0, and clear fuse_valid.
REQ-030 flush=1 in START or WAIT SHALL return to IDLE next cycle with no md_valid and no change to fuse state; flush in IDLE SHALL suppress md_valid.
REQ-031 wb_we=1 with wb_rd!=0 matching the stored rs1 or rs2 SHALL clear fuse_valid; setting fuse_valid on the same edge SHALL take priority.
REQ-032 start_sdivide and start_udivide SHALL never be asserted together, nor outside START.
REQ-033 rv32m=0 in IDLE SHALL give md_valid=0, stall=0, fuse=0.

Reset
REQ-034 reset=1 SHALL immediately force state IDLE; start pulses, stall, md_valid, fuse and md_err to 0; md_result to 0; and clear fuse_valid and the wait counter.
REQ-035 A reset asserted mid-divide SHALL abandon the operation, with no result and no fuse entry after release.

Verification
REQ-036 Multiply: mulhu with a=0xFFFFFFFF, b=2 -> same cycle md_result=0x00000001, md_valid=1, stall=0.
REQ-037 Divide: div with a=100, b=7, div_ready low for 5 cycles then high -> one-cycle start_sdivide, stall through WAIT, DONE md_result=14.
REQ-038 Fuse: rem with the same rs1/rs2 immediately after the divide in REQ-037 -> zero latency, md_result=2, fuse=1, no start pulse.
REQ-039 Fuse invalidation: wb_we=1, wb_rd=rs1 between the divide and rem -> rem stalls and starts the divider again.
REQ-040 Special cases: divu with b=0 -> 0xFFFFFFFF; rem with a=0x80000000, b=-1 -> 0; both with zero latency and no start pulse.
REQ-041 Abnormal termination: div_ready stuck low -> md_err=1 at wait cycle 40, md_result=0; a separate run with reset asserted in WAIT -> all outputs 0 at once, state IDLE.

Source files
------------

// File: rtl/md_issue_ctrl_if.sv
// Issue-side bundle between the EX stage / mul-div datapath and md_issue_ctrl.
// The master drives the instruction, operands and unit results; the slave
// (the controller) returns start pulses, stall and the write-back result.
interface md_issue_ctrl_if;
   logic        rv32m;
   logic [2:0]  func3;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] c_mul;
   logic [31:0] c_mulh;
   logic [31:0] c_mulhsu;
   logic [31:0] c_mulu;
   logic [31:0] c_div;
   logic [31:0] c_divu;
   logic [31:0] c_rem;
   logic [31:0] c_remu;
   logic        div_ready;
   logic        start_sdivide;
   logic        start_udivide;
   logic        stall;
   logic [31:0] md_result;
   logic        md_valid;
   logic        fuse;
   logic        md_err;

   modport master (
      output rv32m, func3, rs1, rs2, a, b, flush, wb_we, wb_rd,
             c_mul, c_mulh, c_mulhsu, c_mulu, c_div, c_divu, c_rem, c_remu,
             div_ready,
      input  start_sdivide, start_udivide, stall, md_result, md_valid,
             fuse, md_err
   );

   modport slave (
      input  rv32m, func3, rs1, rs2, a, b, flush, wb_we, wb_rd,
             c_mul, c_mulh, c_mulhsu, c_mulu, c_div, c_divu, c_rem, c_remu,
             div_ready,
      output start_sdivide, start_udivide, stall, md_result, md_valid,
             fuse, md_err
   );
endinterface

// File: rtl/md_issue_ctrl.sv
// RV32M issue controller: zero-latency multiplies and divide special cases,
// a multi-cycle divide sequence (IDLE/START/WAIT/DONE) with timeout, and a
// one-entry quotient/remainder cache so a div/rem pair on the same operands
// only runs the divider once.
module md_issue_ctrl #(
   parameter int MAX_WAIT = 40
) (
   input logic           clk,
   input logic           reset,
   md_issue_ctrl_if.slave bus
);

   localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
   localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT,
      DONE
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] wait_cnt;
   logic [31:0]   q_reg;
   logic [31:0]   r_reg;
   logic          fuse_valid;
   logic [4:0]    fuse_rs1;
   logic [4:0]    fuse_rs2;
   logic          fuse_uns;
   logic          err_reg;

   logic          start_sdivide;
   logic          start_udivide;
   logic          stall;
   logic [31:0]   md_result;
   logic          md_valid;
   logic          fuse;
   logic          md_err;

   logic          is_div;
   logic          uns;
   logic          want_rem;
   logic          div_by_zero;
   logic          sdiv_ovf;
   logic          fuse_hit;
   logic          ready_seen;
   logic          latch_ok;
   logic          latch_to;
   logic          wb_hit;

   assign is_div      = bus.func3[2];
   assign uns         = bus.func3[0];
   assign want_rem    = bus.func3[1];
   assign div_by_zero = (bus.b == '0);
   assign sdiv_ovf    = !uns && (bus.a == 32'h8000_0000) && (bus.b == '1);
   assign fuse_hit    = fuse_valid && (bus.rs1 == fuse_rs1) &&
                        (bus.rs2 == fuse_rs2) && (uns == fuse_uns);
   // div_ready still reflects the previous (idle) divider in the first WAIT cycle
   assign ready_seen  = bus.div_ready && (wait_cnt != '0);
   assign latch_ok    = (state == WAIT) && !bus.flush && ready_seen;
   assign latch_to    = (state == WAIT) && !bus.flush && !ready_seen &&
                        (wait_cnt == LAST_WAIT);
   assign wb_hit      = bus.wb_we && (bus.wb_rd != '0) &&
                        ((bus.wb_rd == fuse_rs1) || (bus.wb_rd == fuse_rs2));

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Counts WAIT cycles; cleared whenever the FSM is anywhere else.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)              wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
      else                    wait_cnt <= '0;
   end

   // Result latch and fuse cache; a fresh fill wins over write-back invalidation.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_reg      <= '0;
         r_reg      <= '0;
         fuse_valid <= 1'b0;
         fuse_rs1   <= '0;
         fuse_rs2   <= '0;
         fuse_uns   <= 1'b0;
         err_reg    <= 1'b0;
      end else if (latch_ok) begin
         q_reg      <= uns ? bus.c_divu : bus.c_div;
         r_reg      <= uns ? bus.c_remu : bus.c_rem;
         fuse_valid <= 1'b1;
         fuse_rs1   <= bus.rs1;
         fuse_rs2   <= bus.rs2;
         fuse_uns   <= uns;
         err_reg    <= 1'b0;
      end else if (latch_to) begin
         fuse_valid <= 1'b0;
         err_reg    <= 1'b1;
      end else if (wb_hit) begin
         fuse_valid <= 1'b0;
      end
   end

   // Next-state and output decode; reset forces every output low immediately.
   always_comb begin
      state_nxt     = state;
      start_sdivide = 1'b0;
      start_udivide = 1'b0;
      stall         = 1'b0;
      md_result     = '0;
      md_valid      = 1'b0;
      fuse          = 1'b0;
      md_err        = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.rv32m && !bus.flush) begin
               if (!is_div) begin
                  md_valid = 1'b1;
                  unique case (bus.func3[1:0])
                     2'b00:   md_result = bus.c_mul;
                     2'b01:   md_result = bus.c_mulh;
                     2'b10:   md_result = bus.c_mulhsu;
                     default: md_result = bus.c_mulu;
                  endcase
               end else if (div_by_zero) begin
                  md_valid  = 1'b1;
                  md_result = want_rem ? bus.a : '1;
               end else if (sdiv_ovf) begin
                  md_valid  = 1'b1;
                  md_result = want_rem ? '0 : 32'h8000_0000;
               end else if (fuse_hit) begin
                  md_valid  = 1'b1;
                  fuse      = 1'b1;
                  md_result = want_rem ? r_reg : q_reg;
               end else begin
                  stall     = 1'b1;
                  state_nxt = START;
               end
            end
         end
         START: begin
            stall = 1'b1;
            if (bus.flush) begin
               state_nxt = IDLE;
            end else begin
               start_sdivide = !uns;
               start_udivide = uns;
               state_nxt     = WAIT;
            end
         end
         WAIT: begin
            stall = 1'b1;
            if (bus.flush)                        state_nxt = IDLE;
            else if (ready_seen)                  state_nxt = DONE;
            else if (wait_cnt == LAST_WAIT)       state_nxt = DONE;
         end
         DONE: begin
            md_valid  = 1'b1;
            md_err    = err_reg;
            md_result = err_reg ? '0 : (want_rem ? r_reg : q_reg);
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (reset) begin
         state_nxt     = IDLE;
         start_sdivide = 1'b0;
         start_udivide = 1'b0;
         stall         = 1'b0;
         md_result     = '0;
         md_valid      = 1'b0;
         fuse          = 1'b0;
         md_err        = 1'b0;
      end
   end

   assign bus.start_sdivide = start_sdivide;
   assign bus.start_udivide = start_udivide;
   assign bus.stall         = stall;
   assign bus.md_result     = md_result;
   assign bus.md_valid      = md_valid;
   assign bus.fuse          = fuse;
   assign bus.md_err        = md_err;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl: expected results are queued as each
// instruction is issued and popped when md_valid appears.
module tb_md_issue_ctrl;

   logic clk;
   logic reset;
   md_issue_ctrl_if bus();

   md_issue_ctrl #(.MAX_WAIT(40)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] res;
      logic        fuse;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] res, input logic f, input logic e);
      exp_t x;
      x.res  = res;
      x.fuse = f;
      x.err  = e;
      sb.push_back(x);
   endtask

   task automatic check_valid(input string tag);
      exp_t e;
      chk({tag, "_valid"}, {31'b0, bus.md_valid}, 32'd1);
      total++;
      assert (sb.size() != 0) else begin
         bad++;
         $error("FAIL %s_sb observed=empty expected=queued_result", tag);
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, "_res"},  bus.md_result,        e.res);
         chk({tag, "_fuse"}, {31'b0, bus.fuse},    {31'b0, e.fuse});
         chk({tag, "_err"},  {31'b0, bus.md_err},  {31'b0, e.err});
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic look();
      #3;
   endtask

   task automatic wait_valid(input string tag, input int budget, output int n);
      n = 0;
      while (bus.md_valid !== 1'b1 && n < budget) begin
         cyc();
         look();
         n++;
      end
      total++;
      assert (bus.md_valid === 1'b1) else begin
         bad++;
         $error("FAIL %s_bound observed=no_valid_after_%0d expected=valid", tag, n);
      end
   endtask

   function automatic logic [31:0] mul_model(input logic [1:0] f, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] p;
      unique case (f)
         2'd0:    p = {32'b0, x} * {32'b0, y};
         2'd1:    p = {{32{x[31]}}, x} * {{32{y[31]}}, y};
         2'd2:    p = {{32{x[31]}}, x} * {32'b0, y};
         default: p = {32'b0, x} * {32'b0, y};
      endcase
      return (f == 2'd0) ? p[31:0] : p[63:32];
   endfunction

   // Behaves as the multiply/divide datapath; special divide cases get poison
   // so the controller must produce those results itself.
   task automatic set_ops(input logic [31:0] x, input logic [31:0] y);
      bus.a        = x;
      bus.b        = y;
      bus.c_mul    = mul_model(2'd0, x, y);
      bus.c_mulh   = mul_model(2'd1, x, y);
      bus.c_mulhsu = mul_model(2'd2, x, y);
      bus.c_mulu   = mul_model(2'd3, x, y);
      if (y == 32'd0 || (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) begin
         bus.c_div = 32'hDEAD_BEEF;
         bus.c_rem = 32'hDEAD_BEEF;
      end else begin
         bus.c_div = $signed(x) / $signed(y);
         bus.c_rem = $signed(x) % $signed(y);
      end
      if (y == 32'd0) begin
         bus.c_divu = 32'hDEAD_BEEF;
         bus.c_remu = 32'hDEAD_BEEF;
      end else begin
         bus.c_divu = x / y;
         bus.c_remu = x % y;
      end
   endtask

   task automatic issue(input logic [2:0] f, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [31:0] x, input logic [31:0] y);
      bus.rv32m = 1'b1;
      bus.func3 = f;
      bus.rs1   = s1;
      bus.rs2   = s2;
      set_ops(x, y);
   endtask

   task automatic outputs_zero(input string tag);
      chk({tag, "_stall"}, {31'b0, bus.stall},         32'd0);
      chk({tag, "_valid"}, {31'b0, bus.md_valid},      32'd0);
      chk({tag, "_res"},   bus.md_result,              32'd0);
      chk({tag, "_fuse"},  {31'b0, bus.fuse},          32'd0);
      chk({tag, "_err"},   {31'b0, bus.md_err},        32'd0);
      chk({tag, "_ss"},    {31'b0, bus.start_sdivide}, 32'd0);
      chk({tag, "_su"},    {31'b0, bus.start_udivide}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=time_limit expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n;
      logic [31:0] e32;

      reset         = 1'b1;
      bus.flush     = 1'b0;
      bus.wb_we     = 1'b0;
      bus.wb_rd     = '0;
      bus.div_ready = 1'b1;
      issue(3'b000, 5'd1, 5'd2, 32'd5, 32'd6);
      #2;
      outputs_zero("in_reset");
      cyc();
      cyc();
      reset     = 1'b0;
      bus.rv32m = 1'b0;
      look();
      outputs_zero("post_reset");

      // Multiplies: zero latency, result from the matching unit output.
      for (int unsigned i = 0; i < 4; i++) begin
         cyc();
         issue({1'b0, 2'(i)}, 5'd1, 5'd2, 32'hFFFF_FFFF, 32'd2);
         e32 = (i == 3) ? 32'h0000_0001 : mul_model(2'(i), 32'hFFFF_FFFF, 32'd2);
         push(e32, 1'b0, 1'b0);
         look();
         check_valid("mul");
         chk("mul_stall", {31'b0, bus.stall}, 32'd0);
         chk("mul_start", {30'b0, bus.start_sdivide, bus.start_udivide}, 32'd0);
      end

      // div 100/7 with div_ready low for five WAIT cycles.
      cyc();
      issue(3'b100, 5'd1, 5'd2, 32'd100, 32'd7);
      push(32'd14, 1'b0, 1'b0);
      look();
      chk("div_idle_stall", {31'b0, bus.stall}, 32'd1);
      chk("div_idle_valid", {31'b0, bus.md_valid}, 32'd0);
      chk("div_idle_start", {31'b0, bus.start_sdivide}, 32'd0);
      cyc();
      bus.div_ready = 1'b0;
      look();
      chk("div_start_s", {31'b0, bus.start_sdivide}, 32'd1);
      chk("div_start_u", {31'b0, bus.start_udivide}, 32'd0);
      chk("div_start_stall", {31'b0, bus.stall}, 32'd1);
      repeat (5) begin
         cyc();
         look();
         chk("div_wait_stall", {31'b0, bus.stall}, 32'd1);
         chk("div_wait_start", {30'b0, bus.start_sdivide, bus.start_udivide}, 32'd0);
      end
      cyc();
      bus.div_ready = 1'b1;
      look();
      chk("div_wait6_stall", {31'b0, bus.stall}, 32'd1);
      wait_valid("div", 4, n);
      chk("div_lat", n, 32'd1);
      check_valid("div");
      chk("div_done_stall", {31'b0, bus.stall}, 32'd0);

      // rem on the same registers is served from the cache.
      cyc();
      issue(3'b110, 5'd1, 5'd2, 32'd100, 32'd7);
      push(32'd2, 1'b1, 1'b0);
      look();
      check_valid("fuse_rem");
      chk("fuse_stall", {31'b0, bus.stall}, 32'd0);
      chk("fuse_start", {30'b0, bus.start_sdivide, bus.start_udivide}, 32'd0);

      // A write-back to rs1 drops the cache entry.
      cyc();
      bus.rv32m = 1'b0;
      bus.wb_we = 1'b1;
      bus.wb_rd = 5'd1;
      cyc();
      bus.wb_we = 1'b0;
      bus.wb_rd = '0;
      issue(3'b110, 5'd1, 5'd2, 32'd100, 32'd7);
      push(32'd2, 1'b0, 1'b0);
      look();
      chk("inval_stall", {31'b0, bus.stall}, 32'd1);
      chk("inval_valid", {31'b0, bus.md_valid}, 32'd0);
      cyc();
      look();
      chk("inval_start", {31'b0, bus.start_sdivide}, 32'd1);
      cyc();
      look();
      chk("wait1_ignores_ready", {31'b0, bus.stall}, 32'd1);
      cyc();
      look();
      chk("wait2_stall", {31'b0, bus.stall}, 32'd1);
      cyc();
      look();
      check_valid("inval_rem");

      // Special cases: no divider start, zero latency.
      cyc();
      issue(3'b101, 5'd5, 5'd6, 32'd1234, 32'd0);
      push(32'hFFFF_FFFF, 1'b0, 1'b0);
      look();
      check_valid("divu_by0");
      chk("divu_by0_start", {30'b0, bus.start_sdivide, bus.start_udivide}, 32'd0);
      chk("divu_by0_stall", {31'b0, bus.stall}, 32'd0);
      cyc();
      issue(3'b110, 5'd5, 5'd6, 32'h8000_0000, 32'hFFFF_FFFF);
      push(32'd0, 1'b0, 1'b0);
      look();
      check_valid("rem_ovf");
      chk("rem_ovf_start", {30'b0, bus.start_sdivide, bus.start_udivide}, 32'd0);
      chk("rem_ovf_stall", {31'b0, bus.stall}, 32'd0);
      cyc();
      issue(3'b100, 5'd5, 5'd6, 32'h8000_0000, 32'hFFFF_FFFF);
      push(32'h8000_0000, 1'b0, 1'b0);
      look();
      check_valid("div_ovf");
      cyc();
      issue(3'b111, 5'd5, 5'd6, 32'd77, 32'd0);
      push(32'd77, 1'b0, 1'b0);
      look();
      check_valid("remu_by0");

      // Unsigned divide, then a signedness mismatch flushed in START.
      cyc();
      issue(3'b101, 5'd3, 5'd4, 32'hFFFF_FFF0, 32'd3);
      push(32'h5555_5550, 1'b0, 1'b0);
      look();
      chk("divu_stall", {31'b0, bus.stall}, 32'd1);
      cyc();
      look();
      chk("divu_start_u", {31'b0, bus.start_udivide}, 32'd1);
      chk("divu_start_s", {31'b0, bus.start_sdivide}, 32'd0);
      wait_valid("divu", 5, n);
      chk("divu_lat", n, 32'd3);
      check_valid("divu");
      cyc();
      issue(3'b110, 5'd3, 5'd4, 32'hFFFF_FFF0, 32'd3);
      look();
      chk("sign_mismatch_stall", {31'b0, bus.stall}, 32'd1);
      cyc();
      bus.flush = 1'b1;
      look();
      chk("flush_start_valid", {31'b0, bus.md_valid}, 32'd0);
      cyc();
      bus.flush = 1'b0;
      issue(3'b111, 5'd3, 5'd4, 32'hFFFF_FFF0, 32'd3);
      push(32'd0, 1'b1, 1'b0);
      look();
      check_valid("fuse_after_flush");
      chk("fuse_after_flush_stall", {31'b0, bus.stall}, 32'd0);

      // Flush in IDLE suppresses a zero-latency result.
      cyc();
      issue(3'b000, 5'd5, 5'd6, 32'd9, 32'd9);
      bus.flush = 1'b1;
      look();
      chk("flush_idle_valid", {31'b0, bus.md_valid}, 32'd0);
      cyc();
      bus.flush = 1'b0;

      // Divider never answers: timeout after MAX_WAIT wait cycles.
      issue(3'b100, 5'd7, 5'd8, 32'd50, 32'd5);
      bus.div_ready = 1'b0;
      push(32'd0, 1'b0, 1'b1);
      look();
      chk("to_stall", {31'b0, bus.stall}, 32'd1);
      cyc();
      look();
      chk("to_start", {31'b0, bus.start_sdivide}, 32'd1);
      wait_valid("timeout", 60, n);
      chk("timeout_len", n, 32'd41);
      check_valid("timeout");
      cyc();
      bus.div_ready = 1'b1;
      issue(3'b111, 5'd3, 5'd4, 32'hFFFF_FFF0, 32'd3);
      look();
      chk("to_cleared_fuse", {31'b0, bus.stall}, 32'd1);
      cyc();
      cyc();
      bus.flush = 1'b1;
      look();
      chk("flush_wait_stall", {31'b0, bus.stall}, 32'd1);
      cyc();
      bus.flush = 1'b0;
      bus.rv32m = 1'b0;
      look();
      chk("flush_wait_idle_stall", {31'b0, bus.stall}, 32'd0);
      chk("flush_wait_idle_valid", {31'b0, bus.md_valid}, 32'd0);

      // Fill the cache, then reset in the middle of another divide.
      cyc();
      issue(3'b100, 5'd9, 5'd10, 32'd1000, 32'd10);
      push(32'd100, 1'b0, 1'b0);
      look();
      wait_valid("div9", 6, n);
      check_valid("div9");
      cyc();
      issue(3'b101, 5'd11, 5'd12, 32'd1000, 32'd3);
      look();
      chk("rst_mid_stall", {31'b0, bus.stall}, 32'd1);
      cyc();
      cyc();
      look();
      chk("rst_mid_wait_stall", {31'b0, bus.stall}, 32'd1);
      #1;
      reset = 1'b1;
      #1;
      outputs_zero("async_reset");
      cyc();
      cyc();
      reset     = 1'b0;
      bus.rv32m = 1'b0;
      look();
      outputs_zero("after_abandon");
      cyc();
      issue(3'b110, 5'd9, 5'd10, 32'd1000, 32'd10);
      look();
      chk("no_fuse_after_reset", {31'b0, bus.stall}, 32'd1);
      chk("no_fuse_after_reset_f", {31'b0, bus.fuse}, 32'd0);
      cyc();
      bus.flush = 1'b1;
      look();
      chk("reset_flush_valid", {31'b0, bus.md_valid}, 32'd0);
      cyc();
      bus.flush = 1'b0;
      bus.rv32m = 1'b0;
      look();

      total++;
      assert (sb.size() == 0) else begin
         bad++;
         $error("FAIL sb_drain observed=%0d expected=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
